// File: rtl/buckshot_pkg.sv
// Shared types and constants for the buckshot sprite controller.
package buckshot_pkg;

  typedef logic [11:0] rgb12_t;
  typedef logic [3:0]  pal_idx_t;

  typedef enum logic {
    FLASH_IDLE = 1'b0,
    FLASH_ON   = 1'b1
  } flash_state_t;

  localparam pal_idx_t TRANSP_IDX_DEF = 4'hC;
  localparam pal_idx_t FLASH_IDX_DEF  = 4'h3;
  localparam int       SCREEN_W_DEF   = 640;
  localparam int       SCREEN_H_DEF   = 480;

  // A flash recolours opaque texels only, so transparency survives the flash.
  function automatic pal_idx_t select_index(input pal_idx_t q, input logic flash,
                                            input pal_idx_t transp, input pal_idx_t flash_idx);
    if (flash && (q != transp)) begin
      return flash_idx;
    end else begin
      return q;
    end
  endfunction

endpackage

// File: rtl/buckshot_flash_fsm.sv
// Hit-flash sequencer: holds flashing for FLASH_FRAMES frame ticks, retriggered by hit.
module buckshot_flash_fsm
  import buckshot_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic frame_tick,
  output logic flashing
);

  flash_state_t state_r, state_nxt_s;
  logic [7:0]   cnt_r, cnt_nxt_s;
  logic         flashing_r;

  // State, frame counter and registered flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FLASH_IDLE;
      cnt_r      <= 8'd0;
      flashing_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      flashing_r <= (state_nxt_s == FLASH_ON);
    end
  end

  // Next state; a hit always reloads, even on the final frame tick.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      FLASH_IDLE: begin
        if (hit) begin
          state_nxt_s = FLASH_ON;
          cnt_nxt_s   = 8'(FLASH_FRAMES);
        end else begin
          cnt_nxt_s   = 8'd0;
        end
      end
      FLASH_ON: begin
        if (hit) begin
          cnt_nxt_s = 8'(FLASH_FRAMES);
        end else if (frame_tick) begin
          if (cnt_r == 8'd1) begin
            state_nxt_s = FLASH_IDLE;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s   = cnt_r - 8'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = FLASH_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  assign flashing = flashing_r;

endmodule

// File: rtl/buckshot_sprite_ctrl.sv
// Buckshot sprite drawing pipeline: raster -> ROM address -> palette index -> registered RGB,
// with a frame-synchronous position update and the hit-flash sequencer.
module buckshot_sprite_ctrl
  import buckshot_pkg::*;
#(
  parameter int       SPR_W        = 64,
  parameter int       SPR_H        = 32,
  parameter int       SCREEN_W     = SCREEN_W_DEF,
  parameter int       SCREEN_H     = SCREEN_H_DEF,
  parameter pal_idx_t TRANSP_IDX   = TRANSP_IDX_DEF,
  parameter pal_idx_t FLASH_IDX    = FLASH_IDX_DEF,
  parameter int       FLASH_FRAMES = 8,
  parameter int       ADDR_W       = $clog2(SPR_W * SPR_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  rgb12_t            bg_rgb,
  input  logic              pos_valid,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic              pos_ready,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  pal_idx_t          rom_q,
  output pal_idx_t          pal_index,
  input  rgb12_t            pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              flashing
);

  logic [9:0]        act_x_r, act_y_r, pend_x_r, pend_y_r;
  logic              pos_ready_r;
  logic              frame_tick_s, xfer_s, in_box_s;
  logic [9:0]        dx_s, dy_s;
  logic [ADDR_W-1:0] rom_addr_s, rom_addr_r;
  logic              in_box_r, blank_r;
  rgb12_t            bg_r, rgb_s, rgb_r;

  assign frame_tick_s = (DrawX == 10'd0) && (DrawY == 10'(SCREEN_H));
  assign xfer_s       = pos_valid && pos_ready_r;

  // Wrapping subtraction makes pixels left of / above the sprite look far outside the box.
  assign dx_s       = DrawX - act_x_r;
  assign dy_s       = DrawY - act_y_r;
  assign in_box_s   = (dx_s < 10'(SPR_W)) && (dy_s < 10'(SPR_H)) &&
                      (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
  assign rom_addr_s = ADDR_W'(20'(dy_s) * 20'(SPR_W) + 20'(dx_s));

  // Position slot: the active position only moves on a frame tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      act_x_r     <= 10'd0;
      act_y_r     <= 10'd0;
      pend_x_r    <= 10'd0;
      pend_y_r    <= 10'd0;
      pos_ready_r <= 1'b1;
    end else if (frame_tick_s) begin
      if (xfer_s) begin
        act_x_r <= pos_x;
        act_y_r <= pos_y;
      end else if (!pos_ready_r) begin
        act_x_r <= pend_x_r;
        act_y_r <= pend_y_r;
      end
      pos_ready_r <= 1'b1;
    end else if (xfer_s) begin
      pend_x_r    <= pos_x;
      pend_y_r    <= pos_y;
      pos_ready_r <= 1'b0;
    end
  end

  // Pixel pipeline registers: S0 address/flags, then the output colour.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_r <= '0;
      in_box_r   <= 1'b0;
      blank_r    <= 1'b0;
      bg_r       <= 12'h000;
      rgb_r      <= 12'h000;
    end else begin
      rom_addr_r <= rom_addr_s;
      in_box_r   <= in_box_s;
      blank_r    <= blank;
      bg_r       <= bg_rgb;
      rgb_r      <= rgb_s;
    end
  end

  // Palette lookup is idle outside the box; the colour mux picks black, background or sprite.
  always_comb begin
    pal_index = 4'h0;
    rgb_s     = 12'h000;
    if (in_box_r) begin
      pal_index = select_index(rom_q, flashing, TRANSP_IDX, FLASH_IDX);
    end else begin
      pal_index = 4'h0;
    end
    if (!blank_r) begin
      rgb_s = 12'h000;
    end else if (!in_box_r || (rom_q == TRANSP_IDX)) begin
      rgb_s = bg_r;
    end else begin
      rgb_s = pal_rgb;
    end
  end

  buckshot_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .clk       (Clk),
    .rst       (Reset),
    .hit       (hit),
    .frame_tick(frame_tick_s),
    .flashing  (flashing)
  );

  assign pos_ready = pos_ready_r;
  assign rom_addr  = rom_addr_r;
  assign red       = rgb_r[11:8];
  assign green     = rgb_r[7:4];
  assign blue      = rgb_r[3:0];

endmodule

// File: tb/tb_buckshot_sprite_ctrl.sv
// Directed scoreboard bench for buckshot_sprite_ctrl with behavioural ROM and palette.
module tb_buckshot_sprite_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, pos_valid, pos_ready, hit, flashing;
  logic [11:0] bg_rgb, pal_rgb;
  logic [10:0] rom_addr;
  logic [3:0]  rom_q, pal_index, red, green, blue;

  logic [3:0]  rom_mem [2048];

  typedef struct {
    string       tag;
    logic [11:0] rgb;
  } exp_t;
  exp_t q[$];

  int n_asrt = 0;
  int n_fail = 0;

  // Bench-side model state
  logic [9:0] m_ax, m_ay, m_px, m_py;
  logic       m_ready, m_flash;
  int         m_cnt;

  always #5 Clk = ~Clk;

  function automatic logic [11:0] pal_fn(input logic [3:0] idx);
    return {idx, idx ^ 4'hA, ~idx};
  endfunction

  assign rom_q   = rom_mem[rom_addr];
  assign pal_rgb = pal_fn(pal_index);

  buckshot_sprite_ctrl dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .bg_rgb(bg_rgb), .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y),
    .pos_ready(pos_ready), .hit(hit), .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_index(pal_index), .pal_rgb(pal_rgb), .red(red), .green(green),
    .blue(blue), .flashing(flashing)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic [9:0] x, input logic [9:0] y,
                                          input logic bl, input logic [11:0] bg);
    logic [9:0] dx, dy;
    logic [3:0] idx;
    dx = x - m_ax;
    dy = y - m_ay;
    if (!bl) return 12'h000;
    if (!(dx < 10'd64 && dy < 10'd32 && x < 10'd640 && y < 10'd480)) return bg;
    idx = rom_mem[dy * 64 + dx];
    if (idx == 4'hC) return bg;
    return pal_fn(m_flash ? 4'h3 : idx);
  endfunction

  task automatic step(input int x, input int y, input logic bl, input logic [11:0] bg,
                      input logic hv, input logic pv, input int px, input int py,
                      input string tag);
    logic tick, xfer;
    exp_t e;
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; bg_rgb = bg;
    hit = hv; pos_valid = pv; pos_x = 10'(px); pos_y = 10'(py);
    tick = (x == 0) && (y == 480);
    xfer = pv && m_ready;
    if (m_flash) begin
      if (hv) m_cnt = 8;
      else if (tick) begin
        if (m_cnt == 1) m_flash = 1'b0;
        else m_cnt--;
      end
    end else if (hv) begin
      m_flash = 1'b1;
      m_cnt = 8;
    end
    e.tag = tag;
    e.rgb = exp_pix(10'(x), 10'(y), bl, bg);
    q.push_back(e);
    if (tick) begin
      if (xfer) begin m_ax = 10'(px); m_ay = 10'(py); end
      else if (!m_ready) begin m_ax = m_px; m_ay = m_py; end
      m_ready = 1'b1;
    end else if (xfer) begin
      m_px = 10'(px); m_py = 10'(py); m_ready = 1'b0;
    end
    @(posedge Clk);
    #1;
    hit = 1'b0;
    pos_valid = 1'b0;
    chk("pos_ready", 32'(pos_ready), 32'(m_ready));
    chk("flashing", 32'(flashing), 32'(m_flash));
    if (q.size() == 2) begin
      e = q.pop_front();
      chk(e.tag, 32'({red, green, blue}), 32'(e.rgb));
    end
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] bg, input string tag);
    step(x, y, 1'b1, bg, 1'b0, 1'b0, 0, 0, tag);
  endtask

  task automatic tick();
    pix(0, 480, 12'h123, "frame_tick_pix");
  endtask

  task automatic model_reset();
    q.delete();
    m_ax = 10'd0; m_ay = 10'd0; m_px = 10'd0; m_py = 10'd0;
    m_ready = 1'b1; m_flash = 1'b0; m_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 4'(i * 7 + 3);
    rom_mem[0] = 4'h5;
    rom_mem[1] = 4'hC;
    rom_mem[2] = 4'h3;
    Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0; bg_rgb = 12'h000;
    pos_valid = 1'b0; pos_x = 10'd0; pos_y = 10'd0; hit = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_ready", 32'(pos_ready), 32'h1);
    chk("rst_flash", 32'(flashing), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_pal", 32'(pal_index), 32'h0);
    Reset = 1'b0;

    // Place sprite at (100,50)
    step(5, 5, 1'b1, 12'h456, 1'b0, 1'b1, 100, 50, "pre_pos_origin");
    tick();
    pix(100, 50, 12'hABC, "tl_corner");
    chk("tl_addr", 32'(rom_addr), 32'h0);
    chk("tl_pal", 32'(pal_index), 32'h5);
    pix(164, 50, 12'hA11, "right_out");
    pix(99, 50, 12'hA22, "left_out");
    pix(163, 81, 12'hA33, "br_corner");
    chk("br_addr", 32'(rom_addr), 32'd2047);
    pix(101, 50, 12'hA44, "transp");
    pix(102, 50, 12'hA55, "idx3");
    step(120, 60, 1'b0, 12'hA66, 1'b0, 1'b0, 0, 0, "blank0");

    // Mid-frame offer, frame-synchronous apply, coincident offer
    step(300, 200, 1'b1, 12'hB01, 1'b0, 1'b1, 200, 100, "offer");
    pix(100, 50, 12'hB02, "old_pos");
    pix(200, 100, 12'hB03, "new_not_yet");
    tick();
    pix(200, 100, 12'hB04, "new_pos");
    pix(100, 50, 12'hB05, "old_gone");
    step(0, 480, 1'b1, 12'hB06, 1'b0, 1'b1, 250, 150, "coinc_tick");
    pix(250, 150, 12'hB07, "coinc_pos");

    // Hit flash with retrigger after tick 5
    step(10, 10, 1'b1, 12'hC01, 1'b1, 1'b0, 0, 0, "hit");
    pix(251, 150, 12'hC02, "flash_transp");
    pix(252, 150, 12'hC03, "flash_idx3");
    pix(250, 150, 12'hC04, "flash_opq");
    chk("flash_pal", 32'(pal_index), 32'h3);
    for (int i = 0; i < 5; i++) tick();
    step(10, 10, 1'b1, 12'hC05, 1'b1, 1'b0, 0, 0, "rehit");
    for (int i = 0; i < 7; i++) tick();
    chk("flash_hold", 32'(flashing), 32'h1);
    tick();
    chk("flash_end", 32'(flashing), 32'h0);
    pix(250, 150, 12'hC06, "post_flash");

    // Clipping at right/bottom edges
    step(1, 1, 1'b1, 12'hD01, 1'b0, 1'b1, 600, 460, "offer_edge");
    tick();
    pix(600, 460, 12'hD02, "edge_tl");
    pix(639, 479, 12'hD03, "edge_br");
    pix(599, 460, 12'hD04, "edge_left");
    pix(640, 460, 12'hD05, "clip_x");
    pix(663, 479, 12'hD06, "clip_xy");
    pix(0, 461, 12'hD07, "nowrap_0");
    pix(23, 461, 12'hD08, "nowrap_23");

    // Reset mid-line while flashing
    step(610, 465, 1'b1, 12'hE01, 1'b1, 1'b0, 0, 0, "pre_rst_hit");
    pix(620, 470, 12'hE02, "pre_rst");
    pix(30, 470, 12'hE03, "pre_rst_bg");
    Reset = 1'b1;
    #1;
    chk("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("mid_rst_ready", 32'(pos_ready), 32'h1);
    chk("mid_rst_flash", 32'(flashing), 32'h0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    pix(0, 0, 12'hF01, "post_rst_0");
    chk("post_rst_held", 32'({red, green, blue}), 32'h0);
    pix(1, 0, 12'hF02, "post_rst_1");
    pix(2, 0, 12'hF03, "post_rst_2");
    pix(700, 0, 12'hF04, "flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
